// File: rtl/ma_dmem_ctrl_if.sv
// ma_dmem_ctrl_if: pipeline-side and dmem-side signals of the MA-stage memory controller.
// slave is the controller's view; master is the pipeline/dmem environment's view.
interface ma_dmem_ctrl_if;
    logic [3:0]  ma_read;
    logic [2:0]  ma_write;
    logic [31:0] ma_address;
    logic [31:0] ma_writedata;
    logic [31:0] ma_readdata;
    logic        ma_stall;
    logic        ma_fault;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  ma_read, ma_write, ma_address, ma_writedata, mem_readdata, mem_busywait,
        output ma_readdata, ma_stall, ma_fault, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output ma_read, ma_write, ma_address, ma_writedata, mem_readdata, mem_busywait,
        input  ma_readdata, ma_stall, ma_fault, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/ma_dmem_ctrl.sv
// ma_dmem_ctrl: MA-stage load/store controller for a word-only dmem with RMW for SB/SH.
// Defining MA_DMEM_CTRL_PERF_EN adds perf_loads/perf_stores/perf_stall_cycles counters.
module ma_dmem_ctrl #(
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    ma_dmem_ctrl_if.slave bus
`ifdef MA_DMEM_CTRL_PERF_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall_cycles
`endif
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(BUSY_TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_f3;
    logic [1:0]    op_size;
    logic [1:0]    op_lane;
    logic [15:0]   op_wdata;
    logic [3:0]    mem_rd;
    logic [2:0]    mem_wr;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   readdata;
    logic          fault;
    logic          ld_en, st_en, ld_bad, st_bad, req, legal, busy, stall;
    logic [2:0]    f3;
    logic [1:0]    size, lane;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext, merged;

    assign ld_en  = bus.ma_read[3];
    assign st_en  = bus.ma_write[2];
    assign f3     = bus.ma_read[2:0];
    assign size   = bus.ma_write[1:0];
    assign lane   = bus.ma_address[1:0];
    assign busy   = bus.mem_busywait;
    assign ld_bad = (f3 inside {3'b011, 3'b110, 3'b111}) || (f3[1:0] == 2'b01 && lane[0]) ||
                    (f3 == 3'b010 && lane != 2'b00);
    assign st_bad = (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
    assign req    = ld_en | st_en;
    assign legal  = (ld_en ^ st_en) && !(ld_en ? ld_bad : st_bad);

    // Lane selection and extension act on the word arriving from dmem this cycle.
    assign byte_v = bus.mem_readdata[{op_lane, 3'b000} +: 8];
    assign half_v = bus.mem_readdata[{op_lane[1], 4'b0000} +: 16];
    assign ext    = op_f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                    op_f3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
                    op_f3 == 3'b100 ? {24'h0, byte_v} :
                    op_f3 == 3'b101 ? {16'h0, half_v} : bus.mem_readdata;

    always_comb begin
        merged = bus.mem_readdata;
        if (op_size == 2'b00) merged[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        else merged[{op_lane[1], 4'b0000} +: 16] = op_wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_f3     <= '0;
            op_size   <= '0;
            op_lane   <= '0;
            op_wdata  <= '0;
            mem_rd    <= '0;
            mem_wr    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            readdata  <= '0;
            fault     <= 1'b0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        op_f3     <= f3;
                        op_size   <= size;
                        op_lane   <= lane;
                        op_wdata  <= bus.ma_writedata[15:0];
                        mem_addr  <= {bus.ma_address[31:2], 2'b00};
                        mem_wdata <= bus.ma_writedata;
                        if (ld_en) begin
                            state  <= RD;
                            mem_rd <= 4'b1010;
                        end else if (size[1]) begin
                            state  <= WR;
                            mem_wr <= 3'b110;
                        end else begin
                            state  <= RMW_RD;
                            mem_rd <= 4'b1010;
                        end
                    end
                    fault <= req && !legal;
                end
                DONE: state <= IDLE;
                default: begin
                    if (!busy) begin
                        cnt    <= '0;
                        mem_rd <= '0;
                        mem_wr <= '0;
                        if (state == RD) readdata <= ext;
                        if (state == RMW_RD) begin
                            state     <= RMW_WR;
                            mem_wr    <= 3'b110;
                            mem_wdata <= merged;
                        end else begin
                            state <= DONE;
                        end
                    end else if (cnt == TMAX) begin
                        cnt    <= '0;
                        mem_rd <= '0;
                        mem_wr <= '0;
                        state  <= DONE;
                        fault  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Reset also gates the strobes so dmem sees no access on the edge that aborts one.
    assign stall             = reset && ((state == IDLE && legal) || (state != IDLE && state != DONE));
    assign bus.ma_stall      = stall;
    assign bus.ma_fault      = fault;
    assign bus.ma_readdata   = readdata;
    assign bus.mem_read      = mem_rd & {4{reset}};
    assign bus.mem_write     = mem_wr & {3{reset}};
    assign bus.mem_address   = mem_addr;
    assign bus.mem_writedata = mem_wdata;

`ifdef MA_DMEM_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_loads        <= perf_loads + 32'(state == RD && !busy);
            perf_stores       <= perf_stores + 32'((state == WR || state == RMW_WR) && !busy);
            perf_stall_cycles <= perf_stall_cycles + 32'(stall);
        end
    end
`endif
endmodule

// File: tb/tb_ma_dmem_ctrl.sv
// tb_ma_dmem_ctrl: directed stimulus with a scoreboard queue checked by an independent monitor.
module tb_ma_dmem_ctrl;
    typedef struct {
        logic        fault;
        logic        chk_rd;
        logic [31:0] rd;
        int          stall;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy  = 1'b0;
    logic [31:0] mem [16];
    exp_t sb [$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ma_dmem_ctrl_if bus ();
`ifdef MA_DMEM_CTRL_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
    ma_dmem_ctrl #(.BUSY_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles)
    );
`else
    ma_dmem_ctrl #(.BUSY_TIMEOUT(15)) dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    assign bus.mem_readdata = mem[bus.mem_address[5:2]];
    assign bus.mem_busywait = busy;
    always @(posedge clock)
        if (bus.mem_write[2] && !bus.mem_busywait) mem[bus.mem_address[5:2]] <= bus.mem_writedata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a, input logic [31:0] d);
        bus.ma_read = rd;
        bus.ma_write = wr;
        bus.ma_address = a;
        bus.ma_writedata = d;
    endtask

    // Issue one request and hold it until the stall drops, then retire it.
    task automatic op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a, input logic [31:0] d,
                      input int busy_n, input logic e_fault, input logic e_chk, input logic [31:0] e_rd,
                      input int e_stall);
        int n = 0;
        sb.push_back('{e_fault, e_chk, e_rd, e_stall});
        @(posedge clock); #1;
        set_in(rd, wr, a, d);
        busy = busy_n > 0;
        @(negedge clock);
        while (bus.ma_stall && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (n == busy_n + 1) busy = 1'b0;
            @(negedge clock);
        end
        if (n >= 60) begin
            errors++;
            $display("FAIL op_timeout addr=%h actual=stuck required=done", a);
        end
        @(posedge clock); #1;
        set_in(4'h0, 3'h0, 32'h0, 32'h0);
        busy = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        @(negedge clock);
        chk(name, {bus.ma_readdata, bus.ma_fault, bus.ma_stall, bus.mem_read, bus.mem_write},
            {32'h0, 1'b0, 1'b0, 4'h0, 3'h0});
        chk({name, "_bus"}, {bus.mem_address, bus.mem_writedata}, 64'h0);
    endtask

    // Monitor: one response per completed access (stall falling) or fault pulse.
    initial begin
        int run = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                run = 0;
                prev = 1'b0;
            end else begin
                if (!bus.ma_stall) chk("idle_mem_quiet", {bus.mem_read, bus.mem_write}, 7'h0);
                if (bus.ma_stall) begin
                    run++;
                end else if (prev || bus.ma_fault) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_response actual=response required=none");
                    end else begin
                        e = sb.pop_front();
                        chk("fault", 64'(bus.ma_fault), 64'(e.fault));
                        chk("stall_cycles", 64'(run), 64'(e.stall));
                        if (e.chk_rd) chk("readdata", 64'(bus.ma_readdata), 64'(e.rd));
                    end
                    run = 0;
                end
                prev = bus.ma_stall;
            end
        end
    end

    initial begin
        set_in(4'h0, 3'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clock);
        chk_zero("reset_init");
        @(posedge clock); #1;
        reset = 1'b1;
        // Word store/load, byte and half RMW with aligned/extended loads.
        op(4'h0, 3'b110, 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0, 2);
        op(4'b1010, 3'h0, 32'h10, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 2);
        op(4'h0, 3'b100, 32'h11, 32'h000000A5, 0, 1'b0, 1'b0, 32'h0, 3);
        chk("sb_word", 64'(mem[4]), 64'hDEADA5EF);
        op(4'b1000, 3'h0, 32'h11, 32'h0, 0, 1'b0, 1'b1, 32'hFFFFFFA5, 2);
        op(4'b1100, 3'h0, 32'h11, 32'h0, 0, 1'b0, 1'b1, 32'h000000A5, 2);
        op(4'h0, 3'b101, 32'h12, 32'h00008001, 0, 1'b0, 1'b0, 32'h0, 3);
        chk("sh_word", 64'(mem[4]), 64'h8001A5EF);
        op(4'b1001, 3'h0, 32'h12, 32'h0, 0, 1'b0, 1'b1, 32'hFFFF8001, 2);
        op(4'b1101, 3'h0, 32'h12, 32'h0, 0, 1'b0, 1'b1, 32'h00008001, 2);
        // Illegal requests: misaligned, bad funct3/size, load+store together.
        op(4'b1010, 3'h0, 32'h13, 32'h0, 0, 1'b1, 1'b0, 32'h0, 0);
        op(4'h0, 3'b101, 32'h11, 32'h1234, 0, 1'b1, 1'b0, 32'h0, 0);
        op(4'b1011, 3'h0, 32'h10, 32'h0, 0, 1'b1, 1'b0, 32'h0, 0);
        op(4'b1010, 3'b110, 32'h10, 32'h0, 0, 1'b1, 1'b0, 32'h0, 0);
        op(4'h0, 3'b111, 32'h10, 32'h0, 0, 1'b1, 1'b0, 32'h0, 0);
        op(4'b1001, 3'h0, 32'h11, 32'h0, 0, 1'b1, 1'b0, 32'h0, 0);
        chk("faults_no_write", 64'(mem[4]), 64'h8001A5EF);
        // Busywait stretches, then a timeout that leaves readdata untouched.
        op(4'h0, 3'b110, 32'h30, 32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h0, 3);
        op(4'b1010, 3'h0, 32'h30, 32'h0, 0, 1'b0, 1'b1, 32'hCAFEF00D, 2);
        op(4'b1000, 3'h0, 32'h11, 32'h0, 2, 1'b0, 1'b1, 32'hFFFFFFA5, 4);
        op(4'b1010, 3'h0, 32'h10, 32'h0, 20, 1'b1, 1'b1, 32'hFFFFFFA5, 16);
        // Reset in the middle of an RMW read.
        @(posedge clock); #1;
        set_in(4'h0, 3'b100, 32'h24, 32'h77);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        chk_zero("reset_mid1");
        @(posedge clock);
        chk_zero("reset_mid2");
        set_in(4'h0, 3'h0, 32'h0, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", 64'(bus.ma_stall), 64'h0);
        // Reset during RMW_WR must not commit the merged word.
        op(4'h0, 3'b110, 32'h20, 32'h11223344, 0, 1'b0, 1'b0, 32'h0, 2);
        @(posedge clock); #1;
        set_in(4'h0, 3'b100, 32'h20, 32'hFF);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        set_in(4'h0, 3'h0, 32'h0, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        chk("rmw_wr_reset_word", 64'(mem[8]), 64'h11223344);
        op(4'b1010, 3'h0, 32'h20, 32'h0, 0, 1'b0, 1'b1, 32'h11223344, 2);
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
